// File: rtl/adc733_sport_tx_if.sv
// Sample-word handshake between the ADC capture path and the serial-port transmitter.
interface adc733_sport_tx_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/adc733_sport_tx.sv
// Serial-port transmitter: shifts one sample word per frame, MSB first, with a frame sync
// on the MSB bit period and a round-robin channel tag per frame.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no frame; s_ready follows se
// ST_ARM   | word captured, waiting for the next SCLK fall to drive the MSB
// ST_SHIFT | bits on the wire; bit_cnt counts remaining lower bits
module adc733_sport_tx #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 2,
   parameter int NUM_CH  = 6
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic                    se,
   input  logic                    sync,
   adc733_sport_tx_if.slave        s,
   output logic                    SCLK,
   output logic                    SDOFS,
   output logic                    SDO,
   output logic [2:0]              ch_idx,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0]  BIT_TOP  = BC_W'(DATA_W - 1);
   localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_SHIFT
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                sclk_q, sclk_d;
   logic                sdo_q, sdo_d;
   logic                sdofs_q, sdofs_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [2:0]          ch_cnt_q, ch_cnt_d;
   logic [2:0]          frame_ch_q, frame_ch_d;

   logic div_tc;
   logic fall_tick;
   logic ready_int;
   logic accept;

   assign div_tc    = (div_q == DIV_LAST);
   assign fall_tick = se && div_tc && sclk_q;
   assign ready_int = (state_q == ST_IDLE) && se;
   assign accept    = s.s_valid && ready_int;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      sclk_d     = sclk_q;
      sdo_d      = sdo_q;
      sdofs_d    = sdofs_q;
      done_d     = 1'b0;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      ch_cnt_d   = ch_cnt_q;
      frame_ch_d = frame_ch_q;

      if (!se) begin
         div_d  = '0;
         sclk_d = 1'b0;
      end else if (div_tc) begin
         div_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         div_d  = div_q + DIV_W'(1);
      end

      if (sync) begin
         ch_cnt_d = 3'd0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shift_d    = s.s_data;
               // A sync coinciding with accept makes this word channel 0.
               frame_ch_d = sync ? 3'd0 : ch_cnt_q;
               if (sync) begin
                  ch_cnt_d = 3'd1;
               end else begin
                  ch_cnt_d = (ch_cnt_q == CH_LAST) ? 3'd0 : ch_cnt_q + 3'd1;
               end
               state_d    = ST_ARM;
            end
         end

         ST_ARM: begin
            if (!se) begin
               sdo_d   = 1'b0;
               sdofs_d = 1'b0;
               state_d = ST_IDLE;
            end else if (fall_tick) begin
               sdofs_d   = 1'b1;
               sdo_d     = shift_q[DATA_W-1];
               shift_d   = shift_q << 1;
               bit_cnt_d = BIT_TOP;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (!se) begin
               sdo_d   = 1'b0;
               sdofs_d = 1'b0;
               state_d = ST_IDLE;
            end else if (fall_tick) begin
               sdofs_d = 1'b0;
               if (bit_cnt_q != '0) begin
                  sdo_d     = shift_q[DATA_W-1];
                  shift_d   = shift_q << 1;
                  bit_cnt_d = bit_cnt_q - BC_W'(1);
               end else begin
                  sdo_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         sclk_q     <= 1'b0;
         sdo_q      <= 1'b0;
         sdofs_q    <= 1'b0;
         done_q     <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         ch_cnt_q   <= 3'd0;
         frame_ch_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         sdo_q      <= sdo_d;
         sdofs_q    <= sdofs_d;
         done_q     <= done_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         ch_cnt_q   <= ch_cnt_d;
         frame_ch_q <= frame_ch_d;
      end
   end

   // Dropping se silences the wire within the same cycle, not one clock later.
   assign SCLK       = sclk_q && se;
   assign SDO        = sdo_q && se;
   assign SDOFS      = sdofs_q && se;
   assign s.s_ready  = ready_int && rst_l;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = done_q;
   assign ch_idx     = frame_ch_q;

endmodule

// File: tb/tb_adc733_sport_tx.sv
// Bench for adc733_sport_tx: vector table, corner-case sequences and randomized frames
// checked against a word/channel-level model.
module tb_adc733_sport_tx;
   localparam int DATA_W  = 16;
   localparam int CLK_DIV = 2;
   localparam int NUM_CH  = 6;
   localparam int FRAME_BOUND = 2 * CLK_DIV * (DATA_W + 4);

   logic       clk = 1'b0;
   logic       rst_l, se, sync;
   logic       SCLK, SDOFS, SDO, busy, frame_done;
   logic [2:0] ch_idx;

   adc733_sport_tx_if #(.DATA_W(DATA_W)) bus ();

   adc733_sport_tx #(
      .DATA_W (DATA_W),
      .CLK_DIV(CLK_DIV),
      .NUM_CH (NUM_CH)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .se        (se),
      .sync      (sync),
      .s         (bus.slave),
      .SCLK      (SCLK),
      .SDOFS     (SDOFS),
      .SDO       (SDO),
      .ch_idx    (ch_idx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int m_ch;

   typedef struct {
      logic [DATA_W-1:0] data;
      bit                sync_acc;
      int                exp_ch;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int t = 0;
      while (bus.s_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_ready"}, 32'(bus.s_ready), 32'd1);
   endtask

   // Sends one word and observes the whole frame on the wire. sync_at = loop cycle for a
   // mid-frame sync pulse (-1 none); churn keeps s_valid high with s_data changing.
   task automatic send_frame(input logic [DATA_W-1:0] data, input bit sync_acc, input int sync_at,
                             input bit churn, input int exp_ch, input string tag);
      logic [DATA_W-1:0] bits;
      int  nrise, fs_cnt, first_fs, extra_fs, busy_ready;
      bit  done, prev, started;
      wait_ready(tag);
      bus.s_data  = data;
      bus.s_valid = 1'b1;
      sync        = sync_acc;
      @(negedge clk);
      check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
      check({tag, "_ch_at_accept"}, 32'(ch_idx), 32'(exp_ch));
      sync = 1'b0;
      if (!churn) begin
         bus.s_valid = 1'b0;
         bus.s_data  = DATA_W'($urandom);
      end
      bits = '0; nrise = 0; fs_cnt = 0; first_fs = 0; extra_fs = 0; busy_ready = 0;
      done = 1'b0; started = 1'b0; prev = SCLK;
      for (int k = 0; k < FRAME_BOUND && !done; k++) begin
         @(negedge clk);
         if (busy && bus.s_ready) busy_ready++;
         if (SDOFS) begin
            fs_cnt++;
            started = 1'b1;
         end
         if (SCLK && !prev && started) begin
            bits = {bits[DATA_W-2:0], SDO};
            nrise++;
            if (nrise == 1) first_fs = int'(SDOFS);
            else if (SDOFS) extra_fs++;
         end
         prev = SCLK;
         if (frame_done) done = 1'b1;
         sync = (k == sync_at);
         if (churn) bus.s_data = DATA_W'($urandom);
         if (done) bus.s_valid = 1'b0;
      end
      sync = 1'b0;
      bus.s_valid = 1'b0;
      check({tag, "_frame_done_seen"}, 32'(done), 32'd1);
      check({tag, "_bits"}, 32'(bits), 32'(data));
      check({tag, "_bit_count"}, 32'(nrise), 32'(DATA_W));
      check({tag, "_sdofs_cycles"}, 32'(fs_cnt), 32'(2 * CLK_DIV));
      check({tag, "_sdofs_on_msb"}, 32'(first_fs), 32'd1);
      check({tag, "_sdofs_extra"}, 32'(extra_fs), 32'd0);
      check({tag, "_ready_while_busy"}, 32'(busy_ready), 32'd0);
      check({tag, "_idle_at_done"}, {29'd0, busy, SDO, SDOFS}, 32'd0);
      check({tag, "_ch_at_done"}, 32'(ch_idx), 32'(exp_ch));
      @(negedge clk);
      check({tag, "_done_one_clk"}, 32'(frame_done), 32'd0);
   endtask

   // Starts a frame, then kills it after cut_bits bits by dropping se or pulsing reset.
   task automatic cut_frame(input logic [DATA_W-1:0] data, input int exp_ch, input int cut_bits,
                            input bit use_reset, input string tag);
      int nrise = 0, dones = 0;
      bit prev, started = 1'b0;
      wait_ready(tag);
      bus.s_data  = data;
      bus.s_valid = 1'b1;
      @(negedge clk);
      check({tag, "_ch_at_accept"}, 32'(ch_idx), 32'(exp_ch));
      bus.s_valid = 1'b0;
      prev = SCLK;
      for (int k = 0; k < FRAME_BOUND && nrise < cut_bits; k++) begin
         @(negedge clk);
         if (SDOFS) started = 1'b1;
         if (SCLK && !prev && started) nrise++;
         prev = SCLK;
         if (frame_done) dones++;
      end
      check({tag, "_reached_cut"}, 32'(nrise), 32'(cut_bits));
      if (!use_reset) begin
         se = 1'b0;
         #1;
         check({tag, "_wire_zero_same_cycle"}, {29'd0, SCLK, SDO, SDOFS}, 32'd0);
      end else begin
         rst_l = 1'b0;
      end
      @(negedge clk);
      check({tag, "_outputs_cleared"}, {27'd0, SCLK, SDOFS, SDO, frame_done, busy}, 32'd0);
      check({tag, "_not_ready"}, 32'(bus.s_ready), 32'd0);
      check({tag, "_ch_after_cut"}, 32'(ch_idx), use_reset ? 32'd0 : 32'(exp_ch));
      rst_l = 1'b1;
      for (int k = 0; k < FRAME_BOUND; k++) begin
         @(negedge clk);
         if (frame_done) dones++;
      end
      check({tag, "_no_frame_done"}, 32'(dones), 32'd0);
      se = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [DATA_W-1:0] rdata;
      bit sa, churn;
      int sm, ch, gap;

      rst_l = 1'b0; se = 1'b1; sync = 1'b0;
      bus.s_valid = 1'b0; bus.s_data = '0;

      vecs[0] = '{16'hA5C3, 1'b0, 0};
      vecs[1] = '{16'h1234, 1'b0, 1};
      vecs[2] = '{16'hFFFF, 1'b0, 2};
      vecs[3] = '{16'h0000, 1'b0, 3};
      vecs[4] = '{16'h8001, 1'b0, 4};
      vecs[5] = '{16'h7FFE, 1'b0, 5};
      vecs[6] = '{16'h5555, 1'b0, 0};
      vecs[7] = '{16'hAAAA, 1'b1, 0};
      vecs[8] = '{16'h0F0F, 1'b0, 1};
      vecs[9] = '{16'h00FF, 1'b0, 2};

      repeat (3) @(negedge clk);
      check("reset_ready_low", 32'(bus.s_ready), 32'd0);
      check("reset_outputs", {27'd0, SCLK, SDOFS, SDO, frame_done, busy}, 32'd0);
      check("reset_ch_idx", 32'(ch_idx), 32'd0);
      rst_l = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(bus.s_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         send_frame(vecs[i].data, vecs[i].sync_acc, -1, 1'b0, vecs[i].exp_ch,
                    $sformatf("vec%0d", i));
      end

      // Sync while channel 3 is on the wire: that frame keeps 3, the next restarts at 0.
      send_frame(16'h3C3C, 1'b0, 10, 1'b0, 3, "sync_mid");
      send_frame(16'hC3C3, 1'b0, -1, 1'b0, 0, "after_sync");

      cut_frame(16'h6E6E, 1, 8, 1'b0, "se_abort");
      send_frame(16'h9669, 1'b0, -1, 1'b0, 2, "after_abort");

      send_frame(16'h1357, 1'b0, -1, 1'b1, 3, "churn");

      cut_frame(16'h2468, 4, 5, 1'b1, "rst_mid");
      send_frame(16'hBEEF, 1'b0, -1, 1'b0, 0, "after_rst");

      m_ch = 1;
      for (int n = 0; n < 14; n++) begin
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) begin
            sync = ($urandom_range(0, 5) == 0);
            if (sync) m_ch = 0;
            @(negedge clk);
         end
         sync  = 1'b0;
         rdata = DATA_W'($urandom);
         sa    = ($urandom_range(0, 3) == 0);
         sm    = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : -1;
         churn = ($urandom_range(0, 1) == 1);
         ch    = sa ? 0 : m_ch;
         m_ch  = sa ? 1 : (m_ch + 1) % NUM_CH;
         if (sm >= 0) m_ch = 0;
         send_frame(rdata, sa, sm, churn, ch, $sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc733_sport_tx.md
ADC733_SPORT_TX -- requirements
Module: adc733_sport_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample word width.
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period, legal range >= 1.
REQ-003 SHALL have parameter NUM_CH, default 6, channel count for round-robin index, legal range 2..8.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_l  in  1  synchronous, active-low reset.
REQ-006 se  in  1  serial-port enable; 0 = SCLK stopped, port idle.
REQ-007 sync  in  1  one-clk pulse; restarts channel sequence at 0.
REQ-008 s_data  in  DATA_W  sample word to transmit.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_ready  out  1  block can accept a word.
REQ-011 SCLK  out  1  generated serial clock.
REQ-012 SDOFS  out  1  frame sync, high for the MSB bit period.
REQ-013 SDO  out  1  serial data, MSB first.
REQ-014 ch_idx  out  3  channel index of the frame in flight or last sent.
REQ-015 busy  out  1  frame armed or shifting.
REQ-016 frame_done  out  1  one-clk pulse after last bit period ends.

Function
REQ-017 SCLK generator: while se=1, divider counts 0..CLK_DIV-1; at terminal count SCLK toggles and divider wraps to 0.
REQ-018 rise tick = clk where SCLK goes 0->1; fall tick = clk where SCLK goes 1->0; SDO/SDOFS change only on fall ticks, so the receiver samples on SCLK rising edges.
REQ-019 se=0: SCLK=0, divider=0, in the same clk cycle as se is sampled low.
REQ-020 FSM states IDLE, ARM, SHIFT.
REQ-021 s_ready = (state==IDLE) && se, combinational.
REQ-022 Accept = s_valid && s_ready; on accept: shift reg <= s_data; frame_ch <= ch_cnt; ch_cnt <= (ch_cnt==NUM_CH-1) ? 0 : ch_cnt+1; state -> ARM.
REQ-023 ARM: on next fall tick: SDOFS<=1, SDO<=shift[DATA_W-1], bit_cnt<=DATA_W-1, state -> SHIFT.
REQ-024 SHIFT, fall tick, bit_cnt>0: SDOFS<=0, SDO<=next lower bit, bit_cnt decrements.
REQ-025 SHIFT, fall tick, bit_cnt==0: SDO<=0, SDOFS<=0, frame_done<=1 for one clk, state -> IDLE.
REQ-026 SDOFS high for exactly 2*CLK_DIV clk cycles per frame; each bit period is 2*CLK_DIV clk cycles.
REQ-027 Frame length: DATA_W bit periods from SDOFS rise to frame_done.
REQ-028 ch_idx = frame_ch; it is updated only on accept.
REQ-029 sync=1: ch_cnt <= 0; frame in flight keeps its frame_ch.
REQ-030 sync and accept in the same clk: accepted word gets frame_ch=0; ch_cnt <= 1.
REQ-031 se falling in ARM or SHIFT aborts the frame: state -> IDLE, SDO=0, SDOFS=0, no frame_done; ch_cnt is not rolled back.
REQ-032 s_data/s_valid changes while busy have no effect on the frame in flight.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 rst_l=0 at a clk edge: state IDLE, SCLK=0, SDOFS=0, SDO=0, frame_done=0, ch_idx=0, ch_cnt=0, divider=0, bit_cnt=0.
REQ-035 Reset overrides se, sync and accept; a frame in progress is dropped without frame_done.
REQ-036 s_ready is 0 while rst_l=0.

Verification
REQ-037 CLK_DIV=2, se=1, send 0xA5C3: SDOFS high 4 clk with SDO=1; bits on SCLK rises 1010010111000011; one frame_done; ch_idx=0.
REQ-038 Seven back-to-back words: ch_idx sequence 0,1,2,3,4,5,0; s_ready low from accept until the clk after frame_done.
REQ-039 sync pulse while the ch_idx=3 frame shifts: that frame completes with ch_idx=3; next frame ch_idx=0.
REQ-040 se dropped at bit 8 of the frame: SCLK, SDO and SDOFS all 0 in that clk cycle; no frame_done; se reasserted and a new word accepted: full frame restarts at MSB.
REQ-041 rst_l low for 1 clk mid-frame: all outputs at REQ-034 values the next cycle; the next frame reports ch_idx=0.
REQ-042 s_valid held high with changing s_data during a frame: exactly one accept per frame; transmitted bits equal the word captured at accept.
